temp_sensor_reader: RTL

Serial front end for the temperature path: it drives a 3-wire serial temperature ADC (chip-select, serial clock, serial data in), shifts in one 10-bit reading per conversion frame and presents it as a parallel `temperature` word with a one-cycle `sample_valid` strobe. It is the producing end of the `temperature[9:0]` bus consumed by the averaging/display FSM. Conversions free-run while `enable` is high, separated by a programmable idle gap.

---
 rtl/temp_pkg.sv | 14 +
 rtl/temp_sensor_reader_sclk_gen.sv | 42 ++++
 rtl/temp_sensor_reader.sv | 114 +++++++++++
 3 files changed

// File: rtl/temp_pkg.sv
// Shared definitions for the temperature path: reader FSM state codes and the
// default reading width also used by the averaging/display FSM.
package temp_pkg;

  localparam int TEMP_W_DEFAULT = 10;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t START = 2'd1;
  localparam state_t SHIFT = 2'd2;
  localparam state_t DONE  = 2'd3;

endpackage

// File: rtl/temp_sensor_reader_sclk_gen.sv
// Serial clock generator: CLK_DIV-cycle half periods, cleared to low while not
// running. Ticks mark the first high cycle (rise) and last high cycle (fall).
module sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick,
  output logic half_end
);

  localparam int CNT_W = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             sclk_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg  <= '0;
      sclk_reg <= 1'b0;
    end else if (!run) begin
      cnt_reg  <= '0;
      sclk_reg <= 1'b0;
    end else if (cnt_reg == LAST) begin
      cnt_reg  <= '0;
      sclk_reg <= ~sclk_reg;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // half_end: sclk toggles at the coming edge
  assign half_end  = run && (cnt_reg == LAST);
  assign rise_tick = run && sclk_reg && (cnt_reg == '0);
  assign fall_tick = half_end && sclk_reg;
  assign sclk      = sclk_reg;

endmodule

// File: rtl/temp_sensor_reader.sv
// 3-wire serial temperature ADC reader. Optional feature macro TEMP_PARITY_EN
// appends a trailing even-parity bit to each frame and rejects bad frames.
module temp_sensor_reader
  import temp_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int SAMPLE_GAP = 16,
  parameter int TEMP_W     = TEMP_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              sdata,
  output logic              sclk,
  output logic              cs_n,
  output logic [TEMP_W-1:0] temperature,
  output logic              sample_valid,
  output logic              parity_err
);

`ifdef TEMP_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int N     = TEMP_W + PAR_BITS;
  localparam int BIT_W = $clog2(N + 1);
  localparam int GAP_W = $clog2(SAMPLE_GAP + 1);

  state_t            state_reg, state_next;
  logic [GAP_W-1:0]  gap_reg;
  logic [GAP_W:0]    gap_inc;
  logic              gap_done;
  logic [BIT_W-1:0]  bit_reg;
  logic [N-1:0]      shift_reg;
  logic              cs_n_reg;
  logic [TEMP_W-1:0] temp_reg;
  logic              valid_reg;
  logic              perr_reg;
  logic              rise_tick, fall_tick, half_end;
  logic              load, frame_ok;
  logic [TEMP_W-1:0] frame_data;

  sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk       (clk),
    .rst       (rst),
    .run       ((state_reg == START) || (state_reg == SHIFT)),
    .sclk      (sclk),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick),
    .half_end  (half_end)
  );

  // The gap is complete once this IDLE cycle brings the count to SAMPLE_GAP
  assign gap_inc  = {1'b0, gap_reg} + 1'b1;
  assign gap_done = gap_inc >= (GAP_W + 1)'(SAMPLE_GAP);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (gap_done && enable) state_next = START;
      START:   if (half_end) state_next = SHIFT;
      SHIFT:   if (fall_tick && (bit_reg == BIT_W'(N))) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign frame_data = shift_reg[N-1 -: TEMP_W];
`ifdef TEMP_PARITY_EN
  assign frame_ok = ~^shift_reg;
`else
  assign frame_ok = 1'b1;
`endif
  // Outputs are loaded on the edge entering DONE so they show during DONE
  assign load = (state_reg == SHIFT) && (state_next == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      gap_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      cs_n_reg  <= 1'b1;
      temp_reg  <= '0;
      valid_reg <= 1'b0;
      perr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cs_n_reg  <= !((state_next == START) || (state_next == SHIFT));
      valid_reg <= load && frame_ok;
      perr_reg  <= load && !frame_ok;
      if (load && frame_ok) temp_reg <= frame_data;

      if (state_reg == DONE)
        gap_reg <= '0;
      else if (state_reg == IDLE)
        gap_reg <= gap_done ? GAP_W'(SAMPLE_GAP) : gap_inc[GAP_W-1:0];

      if (state_reg != SHIFT)
        bit_reg <= '0;
      else if (rise_tick)
        bit_reg <= bit_reg + 1'b1;

      if (rise_tick) shift_reg <= {shift_reg[N-2:0], sdata};
    end
  end

  assign cs_n         = cs_n_reg;
  assign temperature  = temp_reg;
  assign sample_valid = valid_reg;
  assign parity_err   = perr_reg;

endmodule
